// File: rtl/cpx_mult_sched_pkg.sv
// rtl/cpx_mult_sched_pkg.sv - shared widths, fixed-point format and FSM states for the complex multiply scheduler
package cpx_mult_sched_pkg;

  localparam int CPX_SIZE  = 74;
  localparam int HALF_SIZE = 37;
  localparam int FRAC_BITS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P0,
    S_P1,
    S_P2,
    S_P3,
    S_DONE
  } state_t;

endpackage

// File: rtl/cpx_mult_sched_if.sv
// rtl/cpx_mult_sched_if.sv - request/result bundle between requesters and the complex multiply scheduler
interface cpx_mult_sched_if #(
  parameter int NUM_REQ  = 2,
  parameter int TAG_W    = 1,
  parameter int CPX_SIZE = cpx_mult_sched_pkg::CPX_SIZE
);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*CPX_SIZE-1:0] req_a;
  logic [NUM_REQ*CPX_SIZE-1:0] req_b;
  logic                        out_valid;
  logic                        out_ready;
  logic [CPX_SIZE-1:0]         out_data;
  logic [TAG_W-1:0]            out_tag;
  logic                        busy;

  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_data, out_tag, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_data, out_tag, busy
  );

endinterface

// File: rtl/double_sign_mult.sv
// rtl/double_sign_mult.sv - signed fixed-point multiply, full product shifted down by FRAC and truncated
module double_sign_mult #(
  parameter int WIDTH = 37,
  parameter int FRAC  = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] full;
  logic                      unused_bits;

  assign full = a * b;
  // Dropping the low FRAC bits floors toward minus infinity; upper bits wrap.
  assign p           = full[FRAC +: WIDTH];
  assign unused_bits = ^{full[FRAC-1:0], full[2*WIDTH-1:FRAC+WIDTH]};

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, scanning from ptr+1 upward modulo NUM_REQ
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (i == idx) && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cpx_mult_sched.sv
// rtl/cpx_mult_sched.sv - shares one real multiplier among requesters, computing each complex product in four serial phases
module cpx_mult_sched
  import cpx_mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 1
) (
  input  logic             clk,
  input  logic             rst,
  cpx_mult_sched_if.slave  bus
);

  state_t                      state;
  logic [TAG_W-1:0]            rr_ptr;
  logic [TAG_W-1:0]            cur_tag;
  logic [TAG_W-1:0]            win_tag;
  logic [NUM_REQ-1:0]          grant;
  logic [CPX_SIZE-1:0]         sel_a;
  logic [CPX_SIZE-1:0]         sel_b;
  logic                        accept;
  logic signed [HALF_SIZE-1:0] a_re, a_im, b_re, b_im;
  logic signed [HALF_SIZE-1:0] acc_re, acc_im;
  logic signed [HALF_SIZE-1:0] mul_x, mul_y, mul_p;
  logic                        out_valid_q;
  logic [CPX_SIZE-1:0]         out_data_q;
  logic [TAG_W-1:0]            out_tag_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(TAG_W)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign bus.req_ready = (state == S_IDLE) ? grant : '0;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    win_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a   = bus.req_a[i*CPX_SIZE +: CPX_SIZE];
        sel_b   = bus.req_b[i*CPX_SIZE +: CPX_SIZE];
        win_tag = TAG_W'(i);
      end
    end
  end

  // Operand pairs per phase: ArBr, AiBi, ArBi, AiBr.
  always_comb begin
    mul_x = a_re;
    mul_y = b_re;
    case (state)
      S_P1: begin mul_x = a_im; mul_y = b_im; end
      S_P2: begin mul_x = a_re; mul_y = b_im; end
      S_P3: begin mul_x = a_im; mul_y = b_re; end
      default: begin mul_x = a_re; mul_y = b_re; end
    endcase
  end

  double_sign_mult #(.WIDTH(HALF_SIZE), .FRAC(FRAC_BITS)) u_mult (
    .a (mul_x),
    .b (mul_y),
    .p (mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= TAG_W'(NUM_REQ - 1);
      cur_tag     <= '0;
      a_re        <= '0;
      a_im        <= '0;
      b_re        <= '0;
      b_im        <= '0;
      acc_re      <= '0;
      acc_im      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_re    <= sel_a[CPX_SIZE-1 -: HALF_SIZE];
            a_im    <= sel_a[HALF_SIZE-1:0];
            b_re    <= sel_b[CPX_SIZE-1 -: HALF_SIZE];
            b_im    <= sel_b[HALF_SIZE-1:0];
            cur_tag <= win_tag;
            rr_ptr  <= win_tag;
            state   <= S_P0;
          end
        end
        S_P0: begin
          acc_re <= mul_p;
          state  <= S_P1;
        end
        S_P1: begin
          acc_re <= acc_re - mul_p;
          state  <= S_P2;
        end
        S_P2: begin
          acc_im <= mul_p;
          state  <= S_P3;
        end
        S_P3: begin
          acc_im      <= acc_im + mul_p;
          out_data_q  <= {acc_re, HALF_SIZE'(acc_im + mul_p)};
          out_tag_q   <= cur_tag;
          out_valid_q <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpx_mult_sched.sv
// tb/tb_cpx_mult_sched.sv - scoreboard bench for cpx_mult_sched against a complex-arithmetic reference model
module tb_cpx_mult_sched;
  import cpx_mult_sched_pkg::*;

  localparam int NR = 2;

  typedef struct {
    logic [73:0] data;
    logic [0:0]  tag;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpx_mult_sched_if #(.NUM_REQ(NR), .TAG_W(1)) bus ();

  cpx_mult_sched #(.NUM_REQ(NR), .TAG_W(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          m_ptr;
  bit          m_idle;
  bit          prev_v;
  logic [73:0] a_op[NR];
  logic [73:0] b_op[NR];
  bit          ov_en[NR];
  logic [73:0] ov_data[NR];

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Q20.16 product: exact integer product, floor-divided by 2^16, kept modulo 2^37.
  function automatic logic [36:0] qmul(logic [36:0] x, logic [36:0] y);
    logic signed [73:0] sx, sy, f;
    sx = {{37{x[36]}}, x};
    sy = {{37{y[36]}}, y};
    f  = (sx * sy) >>> 16;
    return f[36:0];
  endfunction

  function automatic logic [73:0] cpx(logic [73:0] a, logic [73:0] b);
    logic [36:0] re, im;
    re = qmul(a[73:37], b[73:37]) - qmul(a[36:0], b[36:0]);
    im = qmul(a[73:37], b[36:0]) + qmul(a[36:0], b[73:37]);
    return {re, im};
  endfunction

  function automatic logic [NR-1:0] pick(logic [NR-1:0] v);
    logic [NR-1:0] g;
    g = '0;
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (m_ptr + k) % NR;
      if (g == '0 && v[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

  task automatic step(bit r, logic [NR-1:0] v, bit ordy);
    logic [NR-1:0] exp_rdy;
    exp_t          e;
    @(negedge clk);
    rst           = r;
    bus.req_valid = v;
    bus.req_a     = {a_op[1], a_op[0]};
    bus.req_b     = {b_op[1], b_op[0]};
    bus.out_ready = ordy;
    #1;
    if (r) begin
      sb.delete();
      m_idle = 1'b1;
      m_ptr  = NR - 1;
    end else begin
      exp_rdy = m_idle ? pick(v) : '0;
      check("req_ready", 128'(bus.req_ready), 128'(exp_rdy));
      check("busy", 128'(bus.busy), 128'(!m_idle));
      if (exp_rdy != '0) begin
        for (int i = 0; i < NR; i++) begin
          if (exp_rdy[i]) begin
            e.data = ov_en[i] ? ov_data[i] : cpx(a_op[i], b_op[i]);
            e.tag  = 1'(i);
            e.due  = cyc + 5;
            sb.push_back(e);
            m_ptr  = i;
          end
        end
        m_idle = 1'b0;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (bus.out_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out actual=tag %0d data %0h required=no result", bus.out_tag, bus.out_data);
          end else begin
            if (!prev_v) check("latency", 128'(cyc), 128'(sb[0].due));
            if (bus.out_ready) begin
              e = sb.pop_front();
              check("out_data", 128'(bus.out_data), 128'(e.data));
              check("out_tag", 128'(bus.out_tag), 128'(e.tag));
              m_idle = 1'b1;
            end else begin
              check("hold_data", 128'(bus.out_data), 128'(sb[0].data));
              check("hold_tag", 128'(bus.out_tag), 128'(sb[0].tag));
            end
          end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
          checks++;
          errors++;
          $display("FAIL out_timeout actual=no out_valid required=out_valid by cycle %0d", sb[0].due);
          void'(sb.pop_front());
        end
        prev_v = bus.out_valid;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      a_op[i] = '0; b_op[i] = '0; ov_en[i] = 1'b0; ov_data[i] = '0;
    end
    m_idle = 1'b1;
    m_ptr  = NR - 1;

    step(1, 2'b00, 1);
    step(1, 2'b00, 1);
    step(0, 2'b00, 1);
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_out_data", 128'(bus.out_data), 128'(0));
    check("rst_out_tag", 128'(bus.out_tag), 128'(0));

    // basic product (2+3i)(4-i) = 11+10i
    a_op[0] = {37'h20000, 37'h30000};
    b_op[0] = {37'h40000, 37'h1FFFFF0000};
    ov_en[0] = 1'b1; ov_data[0] = {37'hB0000, 37'hA0000};
    step(0, 2'b01, 1);
    repeat (8) step(0, 2'b00, 1);

    // contention from reset: req0 (1)(1) = 1, req1 (i)(i) = -1
    step(1, 2'b00, 1);
    a_op[0] = {37'h10000, 37'h0};  b_op[0] = {37'h10000, 37'h0};
    a_op[1] = {37'h0, 37'h10000};  b_op[1] = {37'h0, 37'h10000};
    ov_en[0] = 1'b1; ov_data[0] = {37'h10000, 37'h0};
    ov_en[1] = 1'b1; ov_data[1] = {37'h1FFFFF0000, 37'h0};
    repeat (50) step(0, 2'b11, 1);
    repeat (8) step(0, 2'b00, 1);
    ov_en[0] = 1'b0; ov_en[1] = 1'b0;

    // backpressure with a pending request from req1
    a_op[0] = {37'h3_0000_1234, 37'h0_0055_AA00};
    b_op[0] = {37'h0_0002_8000, 37'h1_FFF0_0000};
    a_op[1] = {37'h0_0001_0000, 37'h0_0000_8000};
    b_op[1] = {37'h1_FFFE_0000, 37'h0_0003_0000};
    step(0, 2'b01, 0);
    repeat (4) step(0, 2'b00, 0);
    repeat (10) step(0, 2'b10, 0);
    step(0, 2'b10, 1);
    step(0, 2'b10, 1);
    repeat (8) step(0, 2'b00, 1);

    // wrap-around: max positive operands, then (-2^19)^2
    a_op[0] = {37'hFFFFFFFFF, 37'h0};
    b_op[0] = {37'hFFFFFFFFF, 37'hFFFFFFFFF};
    step(0, 2'b01, 1);
    repeat (7) step(0, 2'b00, 1);
    a_op[0] = {37'h1800000000, 37'h0};
    b_op[0] = {37'h1800000000, 37'h0};
    step(0, 2'b01, 1);
    repeat (7) step(0, 2'b00, 1);

    // reset in P2 discards the operation and restores rr_ptr
    a_op[0] = {37'h0_0007_0000, 37'h0_0001_0000};
    b_op[0] = {37'h0_0002_0000, 37'h0_0005_0000};
    step(0, 2'b01, 1);
    step(0, 2'b00, 1);
    step(0, 2'b00, 1);
    step(1, 2'b00, 1);
    step(0, 2'b00, 1);
    check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    check("midrst_out_data", 128'(bus.out_data), 128'(0));
    step(0, 2'b11, 1);
    repeat (8) step(0, 2'b00, 1);

    // withdrawn request while busy
    step(0, 2'b01, 1);
    step(0, 2'b10, 1);
    repeat (8) step(0, 2'b00, 1);

    // randomized traffic
    repeat (300) begin
      for (int i = 0; i < NR; i++) begin
        a_op[i] = 74'({$urandom, $urandom, $urandom});
        b_op[i] = 74'({$urandom, $urandom, $urandom});
      end
      step(0, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
    end
    repeat (12) step(0, 2'b00, 1);
    check("sb_empty", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
